// File: rtl/bp_me_wormhole_packet_decode_mem_cmd.sv
// bp_me_wormhole_packet_decode_mem_cmd: reassembles one wormhole mem-command packet into a valid/ready message
module bp_me_wormhole_packet_decode_mem_cmd #(
   parameter int flit_width_p               = 64,
   parameter int cord_width_p               = 7,
   parameter int cid_width_p                = 2,
   parameter int len_width_p                = 4,
   parameter int cce_block_width_p          = 512,
   parameter int cce_mem_msg_header_width_p = 59
) (
   input  logic                                  clk_i,
   input  logic                                  reset_n_i,
   input  logic [flit_width_p-1:0]               link_data_i,
   input  logic                                  link_v_i,
   output logic                                  link_ready_and_o,
   output logic [cce_mem_msg_header_width_p-1:0] mem_cmd_header_o,
   output logic [cce_block_width_p-1:0]          mem_cmd_data_o,
   output logic [cord_width_p-1:0]               src_cord_o,
   output logic [cid_width_p-1:0]                src_cid_o,
   output logic                                  mem_cmd_v_o,
   input  logic                                  mem_cmd_ready_and_i
);
   localparam int hdr_w_lp     = 2*cord_width_p + 2*cid_width_p + len_width_p + cce_mem_msg_header_width_p;
   localparam int max_flits_lp = (hdr_w_lp + cce_block_width_p + flit_width_p - 1) / flit_width_p;
   localparam int buf_w_lp     = max_flits_lp * flit_width_p;
   localparam int src_lsb_lp   = cord_width_p + len_width_p + cid_width_p;

   typedef enum logic {e_recv, e_send} state_e;

   state_e                 state_q, state_d;
   logic [len_width_p-1:0] cnt_q, cnt_d, len_q, len_d, len_in;
   logic [buf_w_lp-1:0]    buf_q, buf_d;
   logic                   last;
   logic                   unused_buf;

   // next-state: write flits while receiving, hold the packet until consumed, then clear the payload
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      buf_d   = buf_q;
      len_in  = link_data_i[cord_width_p +: len_width_p];
      last    = cnt_q == ((cnt_q == '0) ? len_in : len_q);
      if (state_q == e_recv && link_v_i) begin
         for (int k = 0; k < max_flits_lp; k++)
            if (int'(cnt_q) == k) buf_d[k*flit_width_p +: flit_width_p] = link_data_i;
         if (cnt_q == '0) len_d = len_in;
         cnt_d = last ? '0 : cnt_q + len_width_p'(1);
         if (last) state_d = e_send;
      end
      if (state_q == e_send && mem_cmd_ready_and_i) begin
         state_d = e_recv;
         buf_d[buf_w_lp-1:hdr_w_lp] = '0;
      end
   end

   // state register; reset drops any partial packet
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= e_recv;
         cnt_q   <= '0;
         len_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         buf_q   <= buf_d;
      end
   end

   assign link_ready_and_o = state_q == e_recv;
   assign mem_cmd_v_o      = state_q == e_send;
   assign mem_cmd_header_o = buf_q[hdr_w_lp-1 -: cce_mem_msg_header_width_p];
   assign src_cord_o       = buf_q[src_lsb_lp +: cord_width_p];
   assign src_cid_o        = buf_q[src_lsb_lp + cord_width_p +: cid_width_p];
   assign mem_cmd_data_o   = buf_q[hdr_w_lp +: cce_block_width_p];
   assign unused_buf       = ^buf_q;

   // an oversized len field makes extra flits fall off the end of the buffer
   a_flit_fits: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (state_q == e_recv && link_v_i) |-> int'(cnt_q) < max_flits_lp);
endmodule

// File: tb/tb_bp_me_wormhole_packet_decode_mem_cmd.sv
// tb_bp_me_wormhole_packet_decode_mem_cmd: random packets against a scoreboard of expected decoded commands
module tb_bp_me_wormhole_packet_decode_mem_cmd;
   localparam int F  = 64;
   localparam int HW = 59;
   localparam int H  = 7 + 4 + 2 + 7 + 2 + HW;
   localparam int BW = 512;
   localparam int B  = 640;

   typedef struct {
      logic [HW-1:0] hdr;
      logic [6:0]    cord;
      logic [1:0]    cid;
      logic [BW-1:0] data;
   } exp_t;

   logic          clk_i = 0;
   logic          reset_n_i = 0;
   logic [F-1:0]  link_data_i = '0;
   logic          link_v_i = 0;
   logic          link_ready_and_o;
   logic [HW-1:0] mem_cmd_header_o;
   logic [BW-1:0] mem_cmd_data_o;
   logic [6:0]    src_cord_o;
   logic [1:0]    src_cid_o;
   logic          mem_cmd_v_o;
   logic          mem_cmd_ready_and_i = 0;

   exp_t q[$];
   int   checks = 0, errors = 0;
   int   rdy_ctrl = 2;
   int   acc_last_cnt = 0, seen_last = 0;
   bit   expect_reset = 1, final_chk = 0, hs_prev = 0;

   bp_me_wormhole_packet_decode_mem_cmd dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .link_data_i(link_data_i), .link_v_i(link_v_i),
      .link_ready_and_o(link_ready_and_o), .mem_cmd_header_o(mem_cmd_header_o),
      .mem_cmd_data_o(mem_cmd_data_o), .src_cord_o(src_cord_o), .src_cid_o(src_cid_o),
      .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_and_i(mem_cmd_ready_and_i)
   );

   always #5 clk_i = ~clk_i;

   // consumer: 2 = always ready, 1 = stalled, 0 = random
   always @(posedge clk_i) begin
      #1;
      mem_cmd_ready_and_i = rdy_ctrl == 2 ? 1'b1 : rdy_ctrl == 1 ? 1'b0 : ($urandom_range(3) != 0);
   end

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: reset values, handshake timing and the scoreboard front while a command is presented
   always @(negedge clk_i) begin
      if (expect_reset) begin
         chk("rst_ready", BW'(link_ready_and_o), BW'(1));
         chk("rst_v", BW'(mem_cmd_v_o), '0);
         chk("rst_hdr", BW'(mem_cmd_header_o), '0);
         chk("rst_data", mem_cmd_data_o, '0);
         chk("rst_src", BW'({src_cord_o, src_cid_o}), '0);
      end
      if (final_chk) chk("queue_empty", BW'(q.size()), '0);
      if (reset_n_i) begin
         if (hs_prev) chk("ready_after_hs", BW'(link_ready_and_o), BW'(1));
         if (acc_last_cnt != seen_last) begin
            chk("latency_v", BW'(mem_cmd_v_o), BW'(1));
            seen_last = acc_last_cnt;
         end
         if (mem_cmd_v_o) begin
            chk("stall_ready", BW'(link_ready_and_o), '0);
            if (q.size() == 0) chk("unexpected_cmd", BW'(mem_cmd_v_o), '0);
            else begin
               chk("hdr", BW'(mem_cmd_header_o), BW'(q[0].hdr));
               chk("src_cord", BW'(src_cord_o), BW'(q[0].cord));
               chk("src_cid", BW'(src_cid_o), BW'(q[0].cid));
               chk("data", mem_cmd_data_o, q[0].data);
               if (mem_cmd_ready_and_i) void'(q.pop_front());
            end
         end
         hs_prev = mem_cmd_v_o && mem_cmd_ready_and_i;
      end else hs_prev = 0;
   end

   // sends the first nfl flits of a packet; a complete packet is also recorded as expected
   task automatic pkt(input logic [HW-1:0] hdr, input logic [6:0] cord, input logic [1:0] cid,
                      input int len, input logic [BW-1:0] data, input int nfl);
      logic [B-1:0]  p;
      logic [BW-1:0] mask;
      exp_t          e;
      int            nbits, t;
      p = '0;
      p[0 +: 7]   = 7'($urandom);
      p[7 +: 4]   = 4'(len);
      p[11 +: 2]  = 2'($urandom);
      p[13 +: 7]  = cord;
      p[20 +: 2]  = cid;
      p[22 +: HW] = hdr;
      p[H +: BW]  = data;
      nbits = (len + 1) * F - H;
      mask  = nbits >= BW ? '1 : (BW'(1) << nbits) - BW'(1);
      e.hdr = hdr; e.cord = cord; e.cid = cid; e.data = data & mask;
      if (nfl == len + 1) q.push_back(e);
      for (int k = 0; k < nfl; k++) begin
         link_data_i = p[k*F +: F];
         link_v_i    = 1;
         t = 0;
         while (!link_ready_and_o) begin
            @(negedge clk_i);
            t++;
            if (t > 300) begin
               $display("FAIL drv_timeout: flit %0d not accepted", k);
               $fatal(1);
            end
         end
         @(posedge clk_i);
         if (k == len) acc_last_cnt++;
         @(negedge clk_i);
      end
   endtask

   task automatic rnd_pkt(input int len);
      logic [BW-1:0] d;
      for (int i = 0; i < BW/32; i++) d[i*32 +: 32] = $urandom;
      pkt({$urandom, 27'($urandom)}, 7'($urandom), 2'($urandom), len, d, len + 1);
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 300) begin @(negedge clk_i); t++; end
   endtask

   initial begin
      logic [BW-1:0] blk;
      repeat (3) @(posedge clk_i);
      #2 reset_n_i = 1;
      @(posedge clk_i); #2 expect_reset = 0;
      @(negedge clk_i);
      pkt({12'h0, 4'h0, 3'd3, 40'h80_0000_0040}, 7'h15, 2'd1, 1, '0, 2);
      link_v_i = 0;
      pkt({12'h0, 4'h1, 3'd3, 40'h00_0000_1000}, 7'h2A, 2'd2, 2, BW'(64'hDEADBEEF_01234567), 3);
      link_v_i = 0;
      for (int i = 0; i < 64; i++) blk[i*8 +: 8] = 8'(i);
      pkt({12'h0, 4'h1, 3'd6, 40'h00_0000_2000}, 7'h7F, 2'd3, 9, blk, 10);
      link_v_i = 0;
      drain();
      rdy_ctrl = 1;
      rnd_pkt(9);
      fork
         rnd_pkt(3);
         begin repeat (10) @(posedge clk_i); #2 rdy_ctrl = 2; end
      join
      link_v_i = 0;
      drain();
      for (int i = 0; i < 4; i++) rnd_pkt($urandom_range(9, 1));
      link_v_i = 0;
      drain();
      rdy_ctrl = 0;
      for (int i = 0; i < 40; i++) begin
         rnd_pkt($urandom_range(9, 1));
         if ($urandom_range(1)) begin
            link_v_i = 0;
            repeat ($urandom_range(3)) @(negedge clk_i);
         end
      end
      link_v_i = 0;
      rdy_ctrl = 2;
      drain();
      for (int i = 0; i < BW/32; i++) blk[i*32 +: 32] = $urandom;
      pkt(59'h1234_5678_9ABC, 7'h11, 2'd1, 3, blk, 2);
      link_v_i = 0;
      #2 reset_n_i = 0;
      expect_reset = 1;
      @(posedge clk_i); #2 reset_n_i = 1;
      @(posedge clk_i); #2 expect_reset = 0;
      @(negedge clk_i);
      for (int i = 0; i < BW/32; i++) blk[i*32 +: 32] = $urandom;
      pkt(59'h0ABC_DEF0_1234, 7'h22, 2'd2, 3, blk, 4);
      link_v_i = 0;
      drain();
      final_chk = 1;
      @(negedge clk_i);
      final_chk = 0;
      @(negedge clk_i);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
